counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Command-driven controller for the `simple_counter` up/down counter. It arbitrates round-robin between `NREQ` requesters, each issuing "move N steps up/down" commands over valid/ready. It expands each accepted command into a burst of single-cycle `o_inc`/`o_dec` pulses wired to the counter's `i_inc`/`i_dec`, and signals completion per command. It sits between the requesting control logic and a `simple_counter` instance clocked and reset from the same `clock`/`reset`.

## Interface
- `COUNT`, 16: modulus of the driven counter (≥2); must match the counter instance.
- `NREQ`, 2: number of requesters (≥1).
- `STEPW`, 8: width of a per-command step count.
- Derived: `WIDTH = $clog2(COUNT)`, `IDW = (NREQ>1) ? $clog2(NREQ) : 1`.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `i_req_valid`  in  NREQ  command valid per requester.
- `o_req_ready`  out  NREQ  command accepted when valid&&ready at a rising edge.
- `i_req_dir`  in  NREQ  per requester: 0 = increment, 1 = decrement.
- `i_req_steps`  in  NREQ*STEPW  packed step counts; requester k uses bits [k*STEPW +: STEPW].
- `o_inc`  out  1  to counter `i_inc`.
- `o_dec`  out  1  to counter `i_dec`.
- `i_count`  in  WIDTH  counter `o_count`, used for checking only.
- `o_busy`  out  1  high in RUN and DONE.
- `o_done`  out  1  one-cycle pulse at command completion.
- `o_done_id`  out  IDW  requester index of the completed command; valid with `o_done`.
- `o_err`  out  1  sticky count-mismatch flag.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: winner = first k with `i_req_valid[k]`, searching from round-robin pointer `ptr` upward, mod NREQ.
  - `o_req_ready` is one-hot on the winner, combinational from `i_req_valid`; all zero outside IDLE or when no requester is valid.
- Handshake:
  - Latch dir, steps and id.
  - `ptr <= id+1 mod NREQ`.
  - Go to RUN if steps>0, else DONE.
- RUN:
  - Assert registered `o_inc` (dir=0) or `o_dec` (dir=1) every cycle.
  - Decrement the remaining-step counter; leave RUN after exactly `steps` pulse cycles.
  - `o_inc` and `o_dec` are never high together.
- DONE: `o_done=1` and `o_done_id=id` for one cycle, then IDLE.
- Commands are not queued; a requester holds valid and data stable until ready.
- Shadow count `shadow` (WIDTH bits) tracks the counter:
  - On each edge with `o_inc`: `shadow = (shadow==COUNT-1) ? 0 : shadow+1`.
  - On each edge with `o_dec`: `shadow = (shadow==0) ? COUNT-1 : shadow-1`.
- Reset, async and at any time including mid-RUN:
  - FSM to IDLE, in-flight command dropped, `ptr=0`, `shadow=0`.
  - Every output returns to 0: `o_req_ready=0` (no requester is valid at reset release), `o_inc=0`, `o_dec=0`, `o_busy=0`, `o_done=0`, `o_done_id=0`, `o_err=0`.

## Timing
- Handshake at edge E0 → `o_inc`/`o_dec` high from E0 up to edge E_steps (steps cycles).
- `o_done` high during the cycle after the last pulse.
- IDLE again one edge later; the next handshake is possible in that cycle.
- Command period is steps+2 cycles; a zero-step command takes 2 cycles with no pulses.
- `o_busy` rises the cycle after the handshake and falls with the DONE→IDLE edge.
- The counter reflects each pulse one edge after it; `shadow` updates on the same edge.

## Configuration
- `COUNTER_SEQ_CHECK_EN` defined:
  - `shadow` and the compare are compiled in.
  - Each cycle, `i_count != shadow` sets `o_err` at the next edge.
  - `o_err` stays high until reset.
- Undefined: no shadow logic, `i_count` ignored, `o_err` tied 0.

## Test plan
- COUNT=16, req0 inc 5 steps from reset → exactly 5 `o_inc` cycles; `i_count`=5; `o_done` with `o_done_id=0` on cycle 6 after handshake; `o_err=0`.
- req1 dec 3 from 0 → `i_count` 15,14,13; `o_dec` only; `o_done_id=1`.
- Both requesters valid continuously, steps=2 each → accepts alternate 0,1,0,1; each accept 4 cycles apart; never two readies high.
- steps=0 → no pulses; `o_done` one cycle after handshake; counter unchanged.
- inc 20 steps with COUNT=16 → wraps, final `i_count`=4. With `COUNTER_SEQ_CHECK_EN`, force `i_count` off by one for one cycle → `o_err` rises next edge and stays high.
- Assert `reset` 3 cycles into a 10-step RUN → `o_inc`, `o_busy`, `o_done` drop immediately; no `o_done` for the dropped command; the next command behaves as fresh from 0.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: round-robin command arbiter that expands step commands into inc/dec pulse bursts.
// Define COUNTER_SEQ_CHECK_EN to compile in the shadow counter and the sticky o_err mismatch flag.
module counter_sequencer #(
    parameter  int COUNT = 16,
    parameter  int NREQ  = 2,
    parameter  int STEPW = 8,
    localparam int WIDTH = $clog2(COUNT),
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       i_req_valid,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic [NREQ-1:0]       i_req_dir,
    input  logic [NREQ*STEPW-1:0] i_req_steps,
    output logic                  o_inc,
    output logic                  o_dec,
    input  logic [WIDTH-1:0]      i_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [IDW-1:0]        o_done_id,
    output logic                  o_err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [IDW-1:0] ptr, id, win;
    logic [NREQ-1:0] rot;
    logic [STEPW-1:0] rem, win_steps;
    logic found, dir, win_dir, hs;
    // rotate requests so that index 0 is the round-robin pointer
    assign rot = NREQ'({i_req_valid, i_req_valid} >> ptr);
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                win = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end
    always_comb begin
        win_steps = '0;
        win_dir = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_steps = i_req_steps[i*STEPW +: STEPW];
                win_dir = i_req_dir[i];
            end
        end
    end
    assign hs = (state == IDLE) && found;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE) ? (hs ? ((win_steps == '0) ? DONE : RUN) : IDLE) :
                   (state == RUN)  ? ((rem == STEPW'(1)) ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            id  <= '0;
            dir <= 1'b0;
            rem <= '0;
        end else if (hs) begin
            ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
            id  <= win;
            dir <= win_dir;
            rem <= win_steps;
        end else if (state == RUN) begin
            rem <= rem - 1'b1;
        end
    end
    always_comb begin
        o_req_ready = hs ? (NREQ'(1) << win) : '0;
        o_inc = (state == RUN) && !dir;
        o_dec = (state == RUN) && dir;
        o_busy = (state != IDLE);
        o_done = (state == DONE);
        o_done_id = (state == DONE) ? id : '0;
    end
`ifdef COUNTER_SEQ_CHECK_EN
    logic [WIDTH-1:0] shadow;
    logic err;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            err <= 1'b0;
        end else begin
            err <= err | (i_count != shadow);
            if (o_inc) shadow <= (shadow == WIDTH'(COUNT - 1)) ? '0 : shadow + 1'b1;
            else if (o_dec) shadow <= (shadow == '0) ? WIDTH'(COUNT - 1) : shadow - 1'b1;
        end
    end
    assign o_err = err;
`else
    logic unused_count;
    assign unused_count = ^i_count;
    assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed commands against a timeline model of the sequencer,
// with a bench-side counter standing in for simple_counter.
module tb_counter_sequencer;
    localparam int COUNT = 16, NREQ = 2, STEPW = 8, WIDTH = 4, IDW = 1;
    logic clock = 1'b0, reset = 1'b1, glitch = 1'b0;
    logic [NREQ-1:0] valid = '0, dir = '0, ready;
    logic [NREQ*STEPW-1:0] steps = '0;
    logic inc, dec, busy, done, err;
    logic [IDW-1:0] done_id;
    logic [WIDTH-1:0] cnt, count;
    int checks = 0, errors = 0, cyc = 0;
    int acc_at, acc_steps, acc_id, ptr_m, rel, w;
    bit active = 0, acc_dir, err_m = 0;
    logic [NREQ-1:0] er;
    int n_inc, n_dec, n_done, hs_cyc, done_cyc, last_id;
    int acc_q[$], acc_cyc[$];

    counter_sequencer #(.COUNT(COUNT), .NREQ(NREQ), .STEPW(STEPW)) dut (
        .clock(clock), .reset(reset), .i_req_valid(valid), .o_req_ready(ready),
        .i_req_dir(dir), .i_req_steps(steps), .o_inc(inc), .o_dec(dec),
        .i_count(count), .o_busy(busy), .o_done(done), .o_done_id(done_id), .o_err(err)
    );

    always #5 clock = ~clock;
    assign count = cnt ^ WIDTH'(glitch);
    always @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else if (inc) cnt <= WIDTH'((int'(cnt) + 1) % COUNT);
        else if (dec) cnt <= WIDTH'((int'(cnt) + COUNT - 1) % COUNT);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++) if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // timeline model: command accepted in cycle c with s steps pulses in c+1..c+s, done in c+s+1
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            chk("rst_ready", ready, 0);
            chk("rst_inc", inc, 0);
            chk("rst_dec", dec, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_done_id", done_id, 0);
            chk("rst_err", err, 0);
            active = 0;
            ptr_m = 0;
            err_m = 0;
        end else begin
            if (active && cyc - acc_at >= acc_steps + 2) active = 0;
            rel = cyc - acc_at;
            w = active ? -1 : winner(valid, ptr_m);
            er = (w < 0) ? '0 : NREQ'(1) << w;
            chk("ready", ready, er);
            chk("inc", inc, active && !acc_dir && rel >= 1 && rel <= acc_steps);
            chk("dec", dec, active && acc_dir && rel >= 1 && rel <= acc_steps);
            chk("busy", busy, active && rel >= 1);
            chk("done", done, active && rel == acc_steps + 1);
            chk("done_id", done_id, (active && rel == acc_steps + 1) ? acc_id : 0);
            chk("err", err, err_m);
            n_inc += inc;
            n_dec += dec;
            if (done) begin
                n_done++;
                last_id = done_id;
                done_cyc = cyc;
            end
            if (w >= 0) begin
                active = 1;
                acc_at = cyc;
                acc_steps = steps[w*STEPW +: STEPW];
                acc_dir = dir[w];
                acc_id = w;
                ptr_m = (w + 1) % NREQ;
                hs_cyc = cyc;
                acc_q.push_back(w);
                acc_cyc.push_back(cyc);
            end
`ifdef COUNTER_SEQ_CHECK_EN
            if (glitch) err_m = 1;
`endif
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear;
        n_inc = 0; n_dec = 0; n_done = 0;
        acc_q.delete();
        acc_cyc.delete();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic issue(input int k, input bit d, input int s);
        bit ok = 0;
        valid[k] = 1'b1;
        dir[k] = d;
        steps[k*STEPW +: STEPW] = STEPW'(s);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (ready[k]) begin ok = 1; break; end
        end
        chk("accept_timeout", ok, 1);
        tick;
        valid[k] = 1'b0;
    endtask

    task automatic wait_done;
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done) begin ok = 1; break; end
        end
        chk("done_timeout", ok, 1);
        tick;
    endtask

    initial begin
        bit ok;
        repeat (3) tick;
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        clear;
        issue(0, 0, 5);
        wait_done;
        chk("t1_count", cnt, 5);
        chk("t1_inc", n_inc, 5);
        chk("t1_dec", n_dec, 0);
        chk("t1_id", last_id, 0);
        chk("t1_latency", done_cyc - hs_cyc, 6);
        chk("t1_err", err, 0);

        do_reset;
        clear;
        issue(1, 1, 3);
        wait_done;
        chk("t2_count", cnt, 13);
        chk("t2_dec", n_dec, 3);
        chk("t2_inc", n_inc, 0);
        chk("t2_id", last_id, 1);
        chk("t2_latency", done_cyc - hs_cyc, 4);

        clear;
        dir = '0;
        steps = {STEPW'(2), STEPW'(2)};
        valid = '1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            #1;
            if (acc_q.size() >= 4) begin ok = 1; break; end
        end
        chk("t3_timeout", ok, 1);
        tick;
        valid = '0;
        wait_done;
        if (ok) begin
            chk("t3_acc0", acc_q[0], 0);
            chk("t3_acc1", acc_q[1], 1);
            chk("t3_acc2", acc_q[2], 0);
            chk("t3_acc3", acc_q[3], 1);
            for (int i = 1; i < 4; i++) chk("t3_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
        end
        chk("t3_count", cnt, 5);
        chk("t3_done", n_done, 4);

        clear;
        issue(0, 0, 0);
        wait_done;
        chk("t4_latency", done_cyc - hs_cyc, 1);
        chk("t4_inc", n_inc, 0);
        chk("t4_count", cnt, 5);

        do_reset;
        clear;
        issue(1, 0, 20);
        wait_done;
        chk("t5_count", cnt, 4);
        chk("t5_inc", n_inc, 20);
        glitch = 1'b1;
        tick;
        glitch = 1'b0;
        repeat (3) tick;
`ifdef COUNTER_SEQ_CHECK_EN
        chk("t5_err_sticky", err, 1);
`else
        chk("t5_err_tied", err, 0);
`endif

        do_reset;
        issue(0, 0, 10);
        repeat (2) tick;
        chk("t6_pre_inc", inc, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_inc", inc, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        tick;
        tick;
        reset = 1'b0;
        clear;
        repeat (15) tick;
        chk("t6_no_done", n_done, 0);
        chk("t6_count0", cnt, 0);
        issue(0, 0, 2);
        wait_done;
        chk("t6_count", cnt, 2);
        chk("t6_id", last_id, 0);
        chk("t6_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
